decoder_sequencer: RTL and testbench
====================================

Name: decoder_sequencer

Overview:
- Upstream stage of Decoder1/2/3 in the SM83 core.
- Owns the instruction register (IR), CB-prefix mode, interrupt-dispatch mode, the 3-bit M-cycle state counter and the 2-bit T-phase counter.
- Drives the complementary 26-bit decoder input bus `a`, plus the writeback (CLK5) and SeqOut_2 phase strobes consumed by Decoder2/3.

Parameters:
- CB_OPCODE, 8'hCB, prefix opcode that enters CB mode.
- DISPATCH_IR, 8'h00, value forced into IR on interrupt dispatch.

Ports:
- CLK  in  1  core clock; all state on rising edge.
- nRESET  in  1  synchronous active-low reset.
- stall  in  1  memory wait; freezes all state while 1.
- data_in  in  8  opcode byte from the data bus, valid at M-cycle boundary.
- op_done  in  1  decoder asserts in the last M-cycle of the current instruction.
- int_req  in  1  pending enabled interrupt (IF&IE&IME, qualified externally).
- halt_req  in  1  decoder asserts with op_done for HALT.
- a  out  26  decoder input bus; exact mapping in Behaviour.
- writeback  out  1  CLK5 equivalent.
- seq_out2  out  1  SeqOut_2.
- halted  out  1  core in HALT.
- seq_err  out  1  sticky: state counter overflow.

Behaviour:
- Reset (nRESET=0 at posedge, regardless of stall) clears IR=00, cb_mode=0, intr_dispatch=0, state=0, t=0, halted=0, seq_err=0.
- Outputs after reset: a=26'h1555555, writeback=0, seq_out2=1.
- T-phase: t increments every clock with stall=0 and wraps 3→0. The M-cycle boundary ("mb") is t==3 && !stall.
- Phase strobes: writeback = t[0]; seq_out2 = ~t[1].
- At mb with op_done=0: state = state+1. If state==7 already, state holds at 7 and seq_err sets (sticky).
- At mb with op_done=1, state→0 and the next instruction is chosen by priority:
  1. halt_req=1 && int_req=0: halted=1; IR, cb_mode and intr_dispatch are unchanged.
  2. int_req=1 && the current instruction is not the CB prefix: intr_dispatch=1, cb_mode=0, IR=DISPATCH_IR. halt_req is ignored here (interrupt wins).
  3. The current instruction is the CB prefix (IR==CB_OPCODE && cb_mode==0 && intr_dispatch==0): cb_mode=1, IR=data_in. No interrupt may split a prefix from its suffix.
  4. Otherwise: cb_mode=0, intr_dispatch=0, IR=data_in.
- While halted: state is held at 0 and t keeps running. At mb with int_req=1: halted=0, then priority rule 2 applies. op_done is ignored while halted.
- Bus mapping, all combinational from registers, no added latency:
  - a[1]=intr_dispatch, a[0]=~a[1].
  - a[3]=cb_mode, a[2]=~a[3].
  - a[5,7,9,11,13,15,17,19]=IR[7..0] (a[5]=IR7, ..., a[19]=IR0); each even bit a[2k] = ~a[2k+1] for k=2..9.
  - a[21]=state[2], a[20]=~state[2]; a[23]=state[1], a[22]=~state[1]; a[25]=state[0], a[24]=~state[0].
- Invariant: a[2k]^a[2k+1]==1 for all k=0..12, every cycle.
- Simultaneous events:
  - stall=1 at t==3 defers mb.
  - Reset beats everything.
  - An op_done sampled when t!=3 has no effect.

Decomposition:
- Shared package (sm83_seq_pkg):
  - constants CB_OPCODE, DISPATCH_IR;
  - field index constants for `a` (A_INTR, A_CB, A_IR7..A_IR0, A_ST2..A_ST0);
  - a typedef for the 3-bit state.
- One sub-module, `seq_abus_encode`: purely combinational {intr, cb, IR, state} → a[25:0]. It is reused by the decoder unit-test mocks.
- Register/FSM logic stays in decoder_sequencer.

Test Plan:
- Reset hold 2 clocks, then release -> a=26'h1555555, state=0, seq_out2=1, writeback=0. t sequence 0,1,2,3,0; writeback toggles 0,1,0,1; seq_out2 1,1,0,0.
- data_in=8'h3E, op_done=1 at first mb -> IR=3E; a[19:5] reflects 3E with complements; at the next mb with op_done=0, state=1 and a[25]=1, a[24]=0.
- IR=CB, op_done=1, int_req=1, data_in=8'h7C -> cb_mode=1, IR=7C, intr_dispatch=0 (interrupt deferred). At the next op_done with int_req=1 -> intr_dispatch=1, IR=00, cb_mode=0.
- stall=1 for 5 clocks while t==3 -> t, state and IR frozen; the mb occurs on the first clock after stall drops.
- halt_req=1, op_done=1, int_req=0 -> halted=1 and state stays 0 over 3 M-cycles. Raise int_req -> at the next mb halted=0, intr_dispatch=1, IR=00.
- 8 consecutive M-cycles with op_done=0 -> state saturates at 7 and seq_err=1. Reset clears it; nRESET=0 mid-instruction (state=4, cb_mode=1) -> all cleared on that edge.

Source files
------------

// File: rtl/sm83_seq_pkg.sv
// Shared definitions for the SM83 decoder sequencer and its bus encoder.
// Holds the prefix and dispatch opcodes, the bit positions of each true
// (odd-indexed) field on the complementary decoder bus `a`, and the M-cycle
// state type.
package sm83_seq_pkg;

  localparam logic [7:0] CB_OPCODE   = 8'hCB;
  localparam logic [7:0] DISPATCH_IR = 8'h00;

  // True-polarity positions on `a`; the complement of each sits one bit below.
  localparam int A_INTR = 1;
  localparam int A_CB   = 3;
  localparam int A_IR7  = 5;
  localparam int A_IR6  = 7;
  localparam int A_IR5  = 9;
  localparam int A_IR4  = 11;
  localparam int A_IR3  = 13;
  localparam int A_IR2  = 15;
  localparam int A_IR1  = 17;
  localparam int A_IR0  = 19;
  localparam int A_ST2  = 21;
  localparam int A_ST1  = 23;
  localparam int A_ST0  = 25;

  localparam int A_WIDTH = 26;

  typedef logic [2:0] mstate_t;

endpackage

// File: rtl/seq_abus_encode.sv
// Combinational encoder from sequencer registers to the 26-bit complementary
// decoder input bus. Each field drives an odd bit and its inverse drives the
// even bit directly below, so a[2k] ^ a[2k+1] is always 1.
// Ports:
//   intr  - interrupt-dispatch mode
//   cb    - CB-prefix mode
//   ir    - instruction register
//   state - M-cycle state counter
//   a     - encoded decoder bus
module seq_abus_encode
  import sm83_seq_pkg::*;
(
  input  logic          intr,
  input  logic          cb,
  input  logic [7:0]    ir,
  input  mstate_t       state,
  output logic [25:0]   a
);

  logic [25:0] true_bits;

  always_comb begin
    // NOTE: every bit gets a default before the field writes so no partial
    // assignment can leave a latch behind.
    true_bits         = '0;
    true_bits[A_INTR] = intr;
    true_bits[A_CB]   = cb;
    true_bits[A_IR7]  = ir[7];
    true_bits[A_IR6]  = ir[6];
    true_bits[A_IR5]  = ir[5];
    true_bits[A_IR4]  = ir[4];
    true_bits[A_IR3]  = ir[3];
    true_bits[A_IR2]  = ir[2];
    true_bits[A_IR1]  = ir[1];
    true_bits[A_IR0]  = ir[0];
    true_bits[A_ST2]  = state[2];
    true_bits[A_ST1]  = state[1];
    true_bits[A_ST0]  = state[0];
  end

  always_comb begin
    a = '0;
    for (int k = 0; k < A_WIDTH / 2; k++) begin
      a[2*k+1] = true_bits[2*k+1];
      a[2*k]   = ~true_bits[2*k+1];
    end
  end

endmodule

// File: rtl/decoder_sequencer.sv
// Upstream stage of the SM83 decoders. Owns IR, CB-prefix mode,
// interrupt-dispatch mode, the M-cycle state counter and the T-phase counter,
// and presents them on the complementary decoder bus together with the
// writeback (CLK5) and SeqOut_2 phase strobes.
// Ports:
//   CLK       - core clock, rising edge
//   nRESET    - synchronous active-low reset
//   stall     - memory wait, freezes all state
//   data_in   - opcode byte, sampled at the M-cycle boundary
//   op_done   - last M-cycle of the current instruction
//   int_req   - pending enabled interrupt
//   halt_req  - HALT, qualified with op_done
//   a         - decoder input bus
//   writeback - CLK5 strobe
//   seq_out2  - SeqOut_2 strobe
//   halted    - core is in HALT
//   seq_err   - sticky state-counter overflow
module decoder_sequencer
  import sm83_seq_pkg::*;
#(
  parameter logic [7:0] CB_OPCODE_P   = CB_OPCODE,
  parameter logic [7:0] DISPATCH_IR_P = DISPATCH_IR
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic        stall,
  input  logic [7:0]  data_in,
  input  logic        op_done,
  input  logic        int_req,
  input  logic        halt_req,
  output logic [25:0] a,
  output logic        writeback,
  output logic        seq_out2,
  output logic        halted,
  output logic        seq_err
);

  logic [7:0] ir;
  logic       cb_mode;
  logic       intr_dispatch;
  mstate_t    state;
  logic [1:0] t;

  // The CB opcode is only a prefix when it was fetched as a plain opcode,
  // not as a CB suffix and not as the forced dispatch value.
  logic is_prefix;
  assign is_prefix = (ir == CB_OPCODE_P) && !cb_mode && !intr_dispatch;

  always_ff @(posedge CLK) begin
    // NOTE: all state updates are non-blocking so every register sees the
    // pre-edge values of its neighbours.
    if (!nRESET) begin
      ir            <= 8'h00;
      cb_mode       <= 1'b0;
      intr_dispatch <= 1'b0;
      state         <= '0;
      t             <= 2'd0;
      halted        <= 1'b0;
      seq_err       <= 1'b0;
    end else if (!stall) begin
      t <= t + 2'd1;
      if (t == 2'd3) begin
        if (halted) begin
          // Only an interrupt wakes HALT; op_done is meaningless here.
          if (int_req) begin
            halted        <= 1'b0;
            intr_dispatch <= 1'b1;
            cb_mode       <= 1'b0;
            ir            <= DISPATCH_IR_P;
          end
        end else if (op_done) begin
          state <= '0;
          if (halt_req && !int_req) begin
            halted <= 1'b1;
          end else if (int_req && !is_prefix) begin
            intr_dispatch <= 1'b1;
            cb_mode       <= 1'b0;
            ir            <= DISPATCH_IR_P;
          end else if (is_prefix) begin
            cb_mode <= 1'b1;
            ir      <= data_in;
          end else begin
            cb_mode       <= 1'b0;
            intr_dispatch <= 1'b0;
            ir            <= data_in;
          end
        end else if (state == 3'd7) begin
          seq_err <= 1'b1;
        end else begin
          state <= state + 3'd1;
        end
      end
    end
  end

  assign writeback = t[0];
  assign seq_out2  = ~t[1];

  seq_abus_encode u_abus (
    .intr  (intr_dispatch),
    .cb    (cb_mode),
    .ir    (ir),
    .state (state),
    .a     (a)
  );

endmodule

// File: tb/tb_decoder_sequencer.sv
// Directed bench for decoder_sequencer. Internal registers are recovered from
// the bus `a` (true bits) and the phase strobes; expected values are constants
// worked out by hand, with a bench-side copy of the T-phase to place stimulus.
module tb_decoder_sequencer;

  logic        CLK = 1'b0;
  logic        nRESET;
  logic        stall;
  logic [7:0]  data_in;
  logic        op_done;
  logic        int_req;
  logic        halt_req;
  logic [25:0] a;
  logic        writeback;
  logic        seq_out2;
  logic        halted;
  logic        seq_err;

  int total = 0;
  int bad   = 0;
  logic [1:0] tb_t = 2'd0;

  decoder_sequencer dut (
    .CLK       (CLK),
    .nRESET    (nRESET),
    .stall     (stall),
    .data_in   (data_in),
    .op_done   (op_done),
    .int_req   (int_req),
    .halt_req  (halt_req),
    .a         (a),
    .writeback (writeback),
    .seq_out2  (seq_out2),
    .halted    (halted),
    .seq_err   (seq_err)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] ir_of(input logic [25:0] bus);
    return {bus[5], bus[7], bus[9], bus[11], bus[13], bus[15], bus[17], bus[19]};
  endfunction

  function automatic logic [2:0] st_of(input logic [25:0] bus);
    return {bus[21], bus[23], bus[25]};
  endfunction

  function automatic logic pairs_ok(input logic [25:0] bus);
    logic ok = 1'b1;
    for (int k = 0; k < 13; k++) ok &= bus[2*k] ^ bus[2*k+1];
    return ok;
  endfunction

  // One clock; outputs are read 1 ns after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (!nRESET) tb_t = 2'd0;
    else if (!stall) tb_t = tb_t + 2'd1;
  endtask

  task automatic goto_t3();
    while (tb_t != 2'd3) tick();
  endtask

  task automatic test_reset();
    logic [3:0] exp_wb;
    logic [3:0] exp_so2;
    exp_wb  = 4'b1010;  // index = t
    exp_so2 = 4'b0011;
    nRESET = 1'b0; stall = 1'b0; data_in = 8'h00;
    op_done = 1'b0; int_req = 1'b0; halt_req = 1'b0;
    tick(); tick();
    total++; if (a !== 26'h1555555) begin bad++; $display("FAIL reset_a got=%h want=%h", a, 26'h1555555); end
    total++; if (halted !== 1'b0 || seq_err !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", halted, seq_err); end
    nRESET = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (writeback !== exp_wb[i] || seq_out2 !== exp_so2[i]) begin
        bad++; $display("FAIL tphase_%0d got wb=%b so2=%b want wb=%b so2=%b", i, writeback, seq_out2, exp_wb[i], exp_so2[i]);
      end
      if (i < 3) tick();
    end
  endtask

  task automatic test_first_opcode();
    data_in = 8'h3E; op_done = 1'b1;
    tick();
    op_done = 1'b0;
    total++; if (a !== 26'h156AA55) begin bad++; $display("FAIL first_a got=%h want=%h", a, 26'h156AA55); end
    total++; if (writeback !== 1'b0 || seq_out2 !== 1'b1) begin bad++; $display("FAIL tphase_wrap got wb=%b so2=%b want wb=0 so2=1", writeback, seq_out2); end
    goto_t3(); tick();
    total++; if (st_of(a) !== 3'd1 || a[25] !== 1'b1 || a[24] !== 1'b0) begin bad++; $display("FAIL state_step got=%0d a25_24=%b want=1 10", st_of(a), a[25:24]); end
    total++; if (ir_of(a) !== 8'h3E) begin bad++; $display("FAIL ir_hold got=%h want=3e", ir_of(a)); end
  endtask

  task automatic test_cb_prefix();
    goto_t3(); data_in = 8'hCB; op_done = 1'b1;
    tick(); op_done = 1'b0;
    total++; if (ir_of(a) !== 8'hCB || a[3] !== 1'b0 || st_of(a) !== 3'd0) begin bad++; $display("FAIL cb_fetch got ir=%h cb=%b st=%0d want ir=cb cb=0 st=0", ir_of(a), a[3], st_of(a)); end
    goto_t3(); data_in = 8'h7C; op_done = 1'b1; int_req = 1'b1;
    tick(); op_done = 1'b0;
    total++; if (ir_of(a) !== 8'h7C || a[3] !== 1'b1 || a[2] !== 1'b0 || a[1] !== 1'b0) begin bad++; $display("FAIL cb_suffix got ir=%h cb=%b intr=%b want ir=7c cb=1 intr=0", ir_of(a), a[3], a[1]); end
    goto_t3(); data_in = 8'h99; op_done = 1'b1;
    tick(); op_done = 1'b0; int_req = 1'b0;
    total++; if (ir_of(a) !== 8'h00 || a[3] !== 1'b0 || a[1] !== 1'b1 || a[0] !== 1'b0) begin bad++; $display("FAIL cb_then_int got ir=%h cb=%b intr=%b want ir=00 cb=0 intr=1", ir_of(a), a[3], a[1]); end
  endtask

  task automatic test_offphase_op_done();
    op_done = 1'b1; data_in = 8'hAA;
    goto_t3();
    total++; if (ir_of(a) !== 8'h00 || a[1] !== 1'b1 || st_of(a) !== 3'd0) begin bad++; $display("FAIL offphase got ir=%h intr=%b st=%0d want ir=00 intr=1 st=0", ir_of(a), a[1], st_of(a)); end
    op_done = 1'b0;
    tick();
    total++; if (st_of(a) !== 3'd1 || ir_of(a) !== 8'h00) begin bad++; $display("FAIL offphase_mb got st=%0d ir=%h want st=1 ir=00", st_of(a), ir_of(a)); end
    goto_t3(); data_in = 8'h21; op_done = 1'b1;
    tick(); op_done = 1'b0;
    total++; if (ir_of(a) !== 8'h21 || a[1] !== 1'b0 || st_of(a) !== 3'd0) begin bad++; $display("FAIL leave_dispatch got ir=%h intr=%b st=%0d want ir=21 intr=0 st=0", ir_of(a), a[1], st_of(a)); end
  endtask

  task automatic test_stall();
    goto_t3(); tick();  // state 0 -> 1
    goto_t3();
    stall = 1'b1; op_done = 1'b1; data_in = 8'h76;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (writeback !== 1'b1 || seq_out2 !== 1'b0 || ir_of(a) !== 8'h21 || st_of(a) !== 3'd1) begin
        bad++; $display("FAIL stall_%0d got wb=%b so2=%b ir=%h st=%0d want wb=1 so2=0 ir=21 st=1", i, writeback, seq_out2, ir_of(a), st_of(a));
      end
    end
    stall = 1'b0;
    tick(); op_done = 1'b0;
    total++; if (ir_of(a) !== 8'h76 || st_of(a) !== 3'd0 || writeback !== 1'b0 || seq_out2 !== 1'b1) begin bad++; $display("FAIL stall_release got ir=%h st=%0d wb=%b so2=%b want ir=76 st=0 wb=0 so2=1", ir_of(a), st_of(a), writeback, seq_out2); end
  endtask

  task automatic test_halt();
    goto_t3(); halt_req = 1'b1; op_done = 1'b1; int_req = 1'b0;
    tick(); halt_req = 1'b0;
    total++; if (halted !== 1'b1 || st_of(a) !== 3'd0 || ir_of(a) !== 8'h76) begin bad++; $display("FAIL halt_enter got h=%b st=%0d ir=%h want h=1 st=0 ir=76", halted, st_of(a), ir_of(a)); end
    data_in = 8'hAA;  // op_done stays high; must be ignored while halted
    for (int m = 0; m < 3; m++) begin
      goto_t3(); tick();
      total++;
      if (halted !== 1'b1 || st_of(a) !== 3'd0 || ir_of(a) !== 8'h76 || !pairs_ok(a)) begin
        bad++; $display("FAIL halt_hold_%0d got h=%b st=%0d ir=%h a=%h want h=1 st=0 ir=76", m, halted, st_of(a), ir_of(a), a);
      end
    end
    goto_t3(); int_req = 1'b1;
    tick(); int_req = 1'b0; op_done = 1'b0;
    total++; if (halted !== 1'b0 || a[1] !== 1'b1 || ir_of(a) !== 8'h00 || a[3] !== 1'b0) begin bad++; $display("FAIL halt_wake got h=%b intr=%b ir=%h cb=%b want h=0 intr=1 ir=00 cb=0", halted, a[1], ir_of(a), a[3]); end
  endtask

  task automatic test_saturate();
    logic [2:0] exp_st;
    goto_t3(); data_in = 8'h00; op_done = 1'b1;
    tick(); op_done = 1'b0;
    for (int m = 1; m <= 8; m++) begin
      goto_t3(); tick();
      exp_st = (m < 7) ? 3'(m) : 3'd7;
      total++;
      if (st_of(a) !== exp_st || seq_err !== (m == 8) || !pairs_ok(a)) begin
        bad++; $display("FAIL saturate_%0d got st=%0d err=%b a=%h want st=%0d err=%b", m, st_of(a), seq_err, a, exp_st, (m == 8));
      end
    end
    nRESET = 1'b0;
    tick(); nRESET = 1'b1;
    total++; if (seq_err !== 1'b0 || a !== 26'h1555555) begin bad++; $display("FAIL err_clear got err=%b a=%h want err=0 a=1555555", seq_err, a); end
  endtask

  task automatic test_reset_mid();
    goto_t3(); data_in = 8'hCB; op_done = 1'b1; tick();
    goto_t3(); data_in = 8'h12; tick();
    op_done = 1'b0;
    for (int m = 0; m < 4; m++) begin goto_t3(); tick(); end
    total++; if (st_of(a) !== 3'd4 || a[3] !== 1'b1 || ir_of(a) !== 8'h12) begin bad++; $display("FAIL mid_setup got st=%0d cb=%b ir=%h want st=4 cb=1 ir=12", st_of(a), a[3], ir_of(a)); end
    tick();
    nRESET = 1'b0; stall = 1'b1;
    tick();
    total++; if (a !== 26'h1555555 || writeback !== 1'b0 || seq_out2 !== 1'b1 || halted !== 1'b0 || seq_err !== 1'b0) begin bad++; $display("FAIL mid_reset got a=%h wb=%b so2=%b h=%b err=%b want a=1555555 wb=0 so2=1 h=0 err=0", a, writeback, seq_out2, halted, seq_err); end
    nRESET = 1'b1; stall = 1'b0;
    tick();
    total++; if (writeback !== 1'b1 || a !== 26'h1555555) begin bad++; $display("FAIL post_reset got wb=%b a=%h want wb=1 a=1555555", writeback, a); end
  endtask

  initial begin
    test_reset();
    test_first_opcode();
    test_cb_prefix();
    test_offphase_op_done();
    test_stall();
    test_halt();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
